vdp_vram_arbiter: RTL
=====================

// Module: vdp_vram_arbiter
// PURPOSE
//   Shares one single-port synchronous VRAM between the VGA scan fetcher (video) and the CPU.
//   The CPU has a queued write port and an optional prefetched read port.
//   Sits between the CPU-side VDP port logic (already in the hwclk domain) and the VRAM.
//   Video is guaranteed a fixed latency. CPU writes drain in slots the video leaves free.
// PARAMETERS
//   AW           14  VRAM address width (16 KB)
//   WFIFO_DEPTH   4  CPU write queue entries; power of 2, >= 2
// PORTS
//   hwclk        in   1   system clock
//   reset_n      in   1   synchronous, active-low reset
//   vid_req      in   1   video fetch request, one cycle per fetch
//   vid_addr     in   AW  video fetch address
//   vid_data     out  8   video fetch data
//   vid_valid    out  1   vid_data valid, 1-cycle pulse
//   cpu_wr_req   in   1   CPU write pulse (addr/data sampled same cycle)
//   cpu_wr_addr  in   AW  CPU write address
//   cpu_wr_data  in   8   CPU write data
//   cpu_wr_full  out  1   write queue full
//   cpu_wr_ovf   out  1   sticky: a write was dropped
//   cpu_rd_req   in   1   CPU read-prefetch request pulse
//   cpu_rd_addr  in   AW  CPU read address
//   cpu_rd_data  out  8   prefetched read data
//   cpu_rd_valid out  1   cpu_rd_data valid (level; cleared by next cpu_rd_req)
//   mem_addr     out  AW  VRAM address
//   mem_wdata    out  8   VRAM write data
//   mem_we       out  1   VRAM write enable
//   mem_rdata    in   8   VRAM read data, valid 1 cycle after address
// BEHAVIOUR
//   Reset (reset_n=0 at posedge hwclk):
//     - Queue, pending read and pipeline are flushed.
//     - All outputs are 0 from the next cycle, except cpu_wr_full=0 and cpu_wr_ovf=0.
//     - In-flight requests are discarded with no valid pulses. Reset mid-operation behaves identically.
//   Slot grant, one per cycle, registered. Priority: VID > WR > RD.
//     - VID: vid_req=1.
//     - WR: queue not empty.
//     - RD: read pending AND queue empty (write-before-read ordering).
//     - IDLE: otherwise. mem_we=0, mem_addr holds its last value.
//   Timing for a request sampled at edge N:
//     - mem_addr/mem_we are driven during cycle N+1.
//     - mem_rdata is sampled at edge N+2.
//     - vid_data/vid_valid (or cpu_rd_data/cpu_rd_valid) are valid in cycle N+3.
//     - Video latency is fixed at 3 cycles, back-to-back every cycle.
//   Write queue:
//     - FIFO of {addr,data}, depth WFIFO_DEPTH.
//     - A push is accepted if the queue is not full, or a pop occurs in the same cycle.
//     - Otherwise the push is dropped and cpu_wr_ovf is set; it clears only on reset.
//     - cpu_wr_full is registered and reflects occupancy after the current edge's push/pop.
//     - Pointers wrap modulo WFIFO_DEPTH. Count is log2(DEPTH)+1 bits.
//   Read (single pending slot):
//     - cpu_rd_req clears cpu_rd_valid and latches the address.
//     - A new cpu_rd_req while pending replaces the address; the older read's result is suppressed.
//     - A write issued after a read grant never alters that read's returned data.
//   Starvation: WR/RD progress only when vid_req=0. No forced CPU slot.
//   State machine for the issued slot: IDLE -> {VID|WR|RD} each cycle.
//     - A 2-stage tag pipeline (VID/RD/NONE) routes mem_rdata to the correct output.
// CONFIGURATION
//   VDP_ARB_RD_EN defined: the read path is present as described above.
//   VDP_ARB_RD_EN undefined:
//     - cpu_rd_req and cpu_rd_addr are ignored; cpu_rd_data=0 and cpu_rd_valid=0 always.
//     - The RD slot never issues and no read logic is synthesized.
// TESTING
//   1. vid_req held 10 cycles, addr 0x000..0x009, VRAM preloaded with addr[7:0]
//      -> vid_valid continuous from cycle 3, data 0x00..0x09 in order.
//   2. Idle video; 4 writes 0x3800..0x3803 = 0xA0..0xA3 in 4 cycles
//      -> never full-dropped; mem_we 4 cycles; readback via video returns 0xA0..0xA3.
//   3. vid_req held high; 5 CPU writes
//      -> cpu_wr_full=1 after 4th; 5th dropped; cpu_wr_ovf=1; drop vid_req -> 4 writes drain.
//   4. Queue 2 writes to 0x0100 (0x11, then 0x22), then cpu_rd_req 0x0100
//      -> cpu_rd_data=0x22 with cpu_rd_valid=1 (needs VDP_ARB_RD_EN).
//   5. Push on the same edge a pop occurs with queue full -> push accepted, cpu_wr_ovf stays 0.
//   6. reset_n=0 for 1 cycle with 3 writes queued and video in flight
//      -> no mem_we, no valid pulses afterwards; cpu_wr_full=0; cpu_wr_ovf=0.

Source files
------------

// File: rtl/vdp_vram_arbiter.sv
// vdp_vram_arbiter: single-port VRAM shared by video (fixed 3-cycle latency) and queued CPU writes.
// Define VDP_ARB_RD_EN to include the CPU read-prefetch path.
module vdp_vram_arbiter #(
  parameter int AW = 14,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic          hwclk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_data,
  output logic          vid_valid,
  input  logic          cpu_wr_req,
  input  logic [AW-1:0] cpu_wr_addr,
  input  logic [7:0]    cpu_wr_data,
  output logic          cpu_wr_full,
  output logic          cpu_wr_ovf,
  input  logic          cpu_rd_req,
  input  logic [AW-1:0] cpu_rd_addr,
  output logic [7:0]    cpu_rd_data,
  output logic          cpu_rd_valid,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata
);
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = WFIFO_DEPTH[PW:0];
  typedef enum logic [1:0] {S_IDLE, S_VID, S_WR, S_RD} slot_t;
  slot_t slot_q, slot_nxt, tag2;
  logic [AW-1:0] wq_addr [WFIFO_DEPTH];
  logic [7:0] wq_data [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_nxt;
  logic push, pop, rd_kill, rd_ready;
  logic [AW-1:0] rd_addr_q;
  always_comb begin
    slot_nxt = vid_req ? S_VID : (count != '0) ? S_WR : (rd_ready && !rd_kill) ? S_RD : S_IDLE;
    pop = slot_nxt == S_WR;
    push = cpu_wr_req && (count != FULL_CNT || pop);
    count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge hwclk) begin
    if (!reset_n) slot_q <= S_IDLE;
    else slot_q <= slot_nxt;
  end
  always_ff @(posedge hwclk) begin
    if (push) begin
      wq_addr[wr_ptr] <= cpu_wr_addr;
      wq_data[wr_ptr] <= cpu_wr_data;
    end
  end
  // slot_q is tag stage 1 (address on the bus), tag2 marks mem_rdata as valid for it
  always_ff @(posedge hwclk) begin
    if (!reset_n) begin
      tag2 <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cpu_wr_full <= 1'b0;
      cpu_wr_ovf <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      vid_data <= '0;
      vid_valid <= 1'b0;
    end else begin
      tag2 <= (slot_q == S_RD && rd_kill) ? S_IDLE : slot_q;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count_nxt;
      cpu_wr_full <= count_nxt == FULL_CNT;
      cpu_wr_ovf <= cpu_wr_ovf | (cpu_wr_req & ~push);
      mem_addr <= slot_nxt == S_VID ? vid_addr : slot_nxt == S_WR ? wq_addr[rd_ptr] :
                  slot_nxt == S_RD ? rd_addr_q : mem_addr;
      mem_wdata <= pop ? wq_data[rd_ptr] : mem_wdata;
      mem_we <= pop;
      vid_data <= tag2 == S_VID ? mem_rdata : vid_data;
      vid_valid <= tag2 == S_VID;
    end
  end
`ifdef VDP_ARB_RD_EN
  logic rd_pend;
  assign rd_kill = cpu_rd_req;
  assign rd_ready = rd_pend && count == '0;
  // a fresh request kills any older read still in the tag pipeline
  always_ff @(posedge hwclk) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_addr_q <= '0;
      cpu_rd_data <= '0;
      cpu_rd_valid <= 1'b0;
    end else begin
      rd_pend <= cpu_rd_req | (rd_pend & (slot_nxt != S_RD));
      rd_addr_q <= cpu_rd_req ? cpu_rd_addr : rd_addr_q;
      cpu_rd_data <= (!cpu_rd_req && tag2 == S_RD) ? mem_rdata : cpu_rd_data;
      cpu_rd_valid <= !cpu_rd_req && (cpu_rd_valid || tag2 == S_RD);
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{cpu_rd_req, cpu_rd_addr};
  assign rd_kill = 1'b0;
  assign rd_ready = 1'b0;
  assign rd_addr_q = '0;
  assign cpu_rd_data = '0;
  assign cpu_rd_valid = 1'b0;
`endif
endmodule
